comparator_4b: RTL and testbench

Registered 4-bit magnitude comparator producing zero, unsigned-less-than and signed-less-than flags for operands A and B. Flags derive from a single subtraction A − B. The block sits in the datapath beside the ALU and feeds branch/set-less-than decisions. One result is produced per accepted input, with one clock of latency.

---
 rtl/comparator_4b_pkg.sv | 43 ++++
 rtl/subtractor_4b.sv | 36 +++
 rtl/comparator_4b.sv | 89 ++++++++
 tb/tb_comparator_4b.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/comparator_4b_pkg.sv
// Shared types and helpers for the registered magnitude comparator.
//
// Contents:
//   WIDTH_DEFAULT  default operand width (4)
//   cmp_flags_t    packed bundle of every flag the comparator can produce
//   derive_flags   maps the raw subtractor outputs of A - B onto cmp_flags_t
package comparator_4b_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef struct packed {
        logic zf;
        logic sltu;
        logic slt;
        logic cf;
        logic of;
        logic nf;
    } cmp_flags_t;

    // All flags come from one subtraction A + ~B + 1.
    // A missing carry out of the top bit means a borrow, so A < B unsigned.
    // Signed overflow is the carry into the MSB disagreeing with the carry
    // out of it. That is the same as: operands differ in sign and the
    // result sign differs from A's sign.
    function automatic cmp_flags_t derive_flags(
        input logic diff_zero,
        input logic diff_msb,
        input logic carry_out,
        input logic msb_carry_in
    );
        cmp_flags_t flags;
        logic       overflow;
        overflow   = carry_out ^ msb_carry_in;
        flags.zf   = diff_zero;
        flags.sltu = ~carry_out;
        flags.slt  = diff_msb ^ overflow;
        flags.cf   = ~carry_out;
        flags.of   = overflow;
        flags.nf   = diff_msb;
        return flags;
    endfunction

endpackage

// File: rtl/subtractor_4b.sv
// Ripple-borrow subtractor computing A + ~B + 1.
//
// Ports:
//   a, b          WIDTH-bit operands
//   diff          WIDTH-bit difference a - b (modulo 2^WIDTH)
//   carry_out     carry out of the top bit (0 means a borrow occurred)
//   msb_carry_in  carry into the top bit, used for signed overflow
module subtractor_4b
    import comparator_4b_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             carry_out,
    output logic             msb_carry_in
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_inv;

    // Subtraction as addition of the inverted operand.
    // The "+1" enters as the initial carry.
    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
    end

    assign carry_out    = carry[WIDTH];
    assign msb_carry_in = carry[WIDTH - 1];

endmodule

// File: rtl/comparator_4b.sv
// Registered magnitude comparator. It produces zero, unsigned-less-than and
// signed-less-than flags for A vs B, one clock after in_valid.
//
// Optional feature: define COMPARATOR_4B_EXT_FLAGS_EN to add the registered
// CF (borrow), OF (signed overflow) and NF (difference sign) outputs.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A/B are captured on this edge
//   A, B       WIDTH-bit operands (unsigned or two's complement)
//   out_valid  flags belong to the most recently accepted pair
//   ZF         A == B
//   SLTu       A < B unsigned
//   SLT        A < B signed
//   CF, OF, NF extended flags (only with COMPARATOR_4B_EXT_FLAGS_EN)
module comparator_4b
    import comparator_4b_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             ZF,
    output logic             SLTu,
    output logic             SLT
`ifdef COMPARATOR_4B_EXT_FLAGS_EN
    ,
    output logic             CF,
    output logic             OF,
    output logic             NF
`endif
);

    logic [WIDTH-1:0] diff;
    logic             carry_out;
    logic             msb_carry_in;
    cmp_flags_t       flags_d;
    cmp_flags_t       flags_q;
    logic             valid_q;

    subtractor_4b #(
        .WIDTH(WIDTH)
    ) u_sub (
        .a           (A),
        .b           (B),
        .diff        (diff),
        .carry_out   (carry_out),
        .msb_carry_in(msb_carry_in)
    );

    assign flags_d = derive_flags(diff == '0, diff[WIDTH-1], carry_out, msb_carry_in);

    // Single output stage. out_valid follows in_valid every edge.
    // The flags only load on accepted samples, so they hold through idle
    // cycles. Reset clears everything at once, regardless of the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            flags_q <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign ZF        = flags_q.zf;
    assign SLTu      = flags_q.sltu;
    assign SLT       = flags_q.slt;

`ifdef COMPARATOR_4B_EXT_FLAGS_EN
    assign CF = flags_q.cf;
    assign OF = flags_q.of;
    assign NF = flags_q.nf;
`else
    // The extended flags are still computed and registered here.
    // They have no port in this build, so they are collected and dropped.
    logic unused_ext_flags;
    assign unused_ext_flags = ^{flags_q.cf, flags_q.of, flags_q.nf};
`endif

endmodule

// File: tb/tb_comparator_4b.sv
// Self-checking bench for comparator_4b.
// The reference model works on plain integers: unsigned and signed values
// of A and B are compared directly. Expected outputs are held between
// accepted samples and cleared by reset.
module tb_comparator_4b;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       out_valid;
    logic       ZF;
    logic       SLTu;
    logic       SLT;
`ifdef COMPARATOR_4B_EXT_FLAGS_EN
    logic       CF;
    logic       OF;
    logic       NF;
`endif

    int checks = 0;
    int errors = 0;

    // Expected output state of the reference model
    logic exp_valid;
    logic exp_zf;
    logic exp_sltu;
    logic exp_slt;
    logic exp_cf;
    logic exp_of;
    logic exp_nf;

    comparator_4b #(
        .WIDTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .ZF       (ZF),
        .SLTu     (SLTu),
        .SLT      (SLT)
`ifdef COMPARATOR_4B_EXT_FLAGS_EN
        ,
        .CF       (CF),
        .OF       (OF),
        .NF       (NF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Interpret a 4-bit pattern as a two's complement integer
    function automatic int toSigned(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Reference model: evaluates a sample from its arithmetic meaning
    task automatic modelAccept(input logic [3:0] a, input logic [3:0] b);
        int ua;
        int ub;
        int sa;
        int sb;
        int sdiff;
        ua       = int'(a);
        ub       = int'(b);
        sa       = toSigned(a);
        sb       = toSigned(b);
        sdiff    = sa - sb;
        exp_zf   = (ua == ub);
        exp_sltu = (ua < ub);
        exp_slt  = (sa < sb);
        exp_cf   = (ua < ub);
        exp_of   = (sdiff > 7) || (sdiff < -8);
        exp_nf   = (((ua - ub + 16) % 16) >= 8);
    endtask

    task automatic modelReset();
        exp_valid = 1'b0;
        exp_zf    = 1'b0;
        exp_sltu  = 1'b0;
        exp_slt   = 1'b0;
        exp_cf    = 1'b0;
        exp_of    = 1'b0;
        exp_nf    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%b expected=%b at t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".out_valid"}, out_valid, exp_valid);
        checkOutput({tag, ".ZF"}, ZF, exp_zf);
        checkOutput({tag, ".SLTu"}, SLTu, exp_sltu);
        checkOutput({tag, ".SLT"}, SLT, exp_slt);
`ifdef COMPARATOR_4B_EXT_FLAGS_EN
        checkOutput({tag, ".CF"}, CF, exp_cf);
        checkOutput({tag, ".OF"}, OF, exp_of);
        checkOutput({tag, ".NF"}, NF, exp_nf);
`endif
    endtask

    // Drive one cycle and check just after the edge.
    // Then scramble A/B between edges and check that the outputs do not move.
    task automatic applyStimulus(input string tag, input logic v,
                                 input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        if (v) modelAccept(a, b);
        exp_valid = v;
        #1;
        checkAll(tag);
        A = 4'($urandom);
        B = 4'($urandom);
        #2;
        checkAll({tag, ".hold"});
    endtask

    // Checks the named flag values directly against the test plan.
    // This is independent of the model.
    task automatic checkPlan(input string tag, input logic zf, input logic sltu, input logic slt);
        checkOutput({tag, ".planZF"}, ZF, zf);
        checkOutput({tag, ".planSLTu"}, SLTu, sltu);
        checkOutput({tag, ".planSLT"}, SLT, slt);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 4'h0;
        B        = 4'h0;
        modelReset();
        #2;
        checkAll("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors from the test plan
        applyStimulus("a7_bE", 1'b1, 4'h7, 4'hE);
        checkPlan("a7_bE", 1'b0, 1'b1, 1'b0);
        applyStimulus("aE_b7", 1'b1, 4'hE, 4'h7);
        checkPlan("aE_b7", 1'b0, 1'b0, 1'b1);
        applyStimulus("a3_b6", 1'b1, 4'h3, 4'h6);
        checkPlan("a3_b6", 1'b0, 1'b1, 1'b1);
        applyStimulus("a6_b3", 1'b1, 4'h6, 4'h3);
        checkPlan("a6_b3", 1'b0, 1'b0, 1'b0);
        applyStimulus("a6_b6", 1'b1, 4'h6, 4'h6);
        checkPlan("a6_b6", 1'b1, 1'b0, 1'b0);
        applyStimulus("a8_b7", 1'b1, 4'h8, 4'h7);
        checkPlan("a8_b7", 1'b0, 1'b0, 1'b1);
`ifdef COMPARATOR_4B_EXT_FLAGS_EN
        checkOutput("a8_b7.planOF", OF, 1'b1);
`endif
        applyStimulus("a0_bF", 1'b1, 4'h0, 4'hF);
        checkPlan("a0_bF", 1'b0, 1'b1, 1'b0);
`ifdef COMPARATOR_4B_EXT_FLAGS_EN
        checkOutput("a0_bF.planCF", CF, 1'b1);
`endif

        // Five back-to-back vectors, then an idle edge that must hold flags
        applyStimulus("b2b0", 1'b1, 4'h1, 4'h9);
        applyStimulus("b2b1", 1'b1, 4'hF, 4'h0);
        applyStimulus("b2b2", 1'b1, 4'h8, 4'h8);
        applyStimulus("b2b3", 1'b1, 4'h7, 4'h8);
        applyStimulus("b2b4", 1'b1, 4'h8, 4'h0);
        applyStimulus("idle", 1'b0, 4'h3, 4'h3);
        checkPlan("idle", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges while a result is valid
        applyStimulus("preRst", 1'b1, 4'h2, 4'h2);
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("rstAsync");
        in_valid = 1'b1;
        A        = 4'h0;
        B        = 4'h5;
        @(posedge clk);
        #1;
        checkAll("rstHeld");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checkAll("postRstIdle");
        applyStimulus("postRstFirst", 1'b1, 4'h4, 4'hC);

        // Randomized traffic with occasional idle cycles
        for (int i = 0; i < 60; i++) begin
            applyStimulus($sformatf("rand%0d", i), ($urandom_range(0, 3) != 0),
                          4'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
